// File: rtl/fpu_pkg.sv
// Shared constants and types for the binary32 adder post-alignment datapath.
package fpu_pkg;
    localparam int MW      = 28;
    localparam int EW      = 8;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int CARRY  = 27;
    localparam int HIDDEN = 26;
    localparam int LSB_B  = 3;
    localparam int GRD    = 2;
    localparam int RND    = 1;
    localparam int STK    = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] NINF = 32'hFF80_0000;

    typedef enum logic [2:0] {IDLE, ADD, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized extended mantissa; flags exponent overflow.
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic [MW-1:0] i_m,
    input  logic [EW+1:0] i_e,
    output logic [22:0]   o_frac,
    output logic [EW-1:0] o_e,
    output logic          o_ovf
);
    logic          w_inc;
    logic [24:0]   w_f25;
    logic [EW+1:0] w_e;
    logic          w_unused;

    // Increment on G unless the tie would land on an odd LSB... i.e. ties go even.
    assign w_inc    = i_m[GRD] & (i_m[RND] | i_m[STK] | i_m[LSB_B]);
    assign w_f25    = {1'b0, i_m[HIDDEN:LSB_B]} + {24'd0, w_inc};
    assign o_frac   = w_f25[24] ? w_f25[23:1] : w_f25[22:0];
    assign w_e      = i_e + {{(EW+1){1'b0}}, w_f25[24]};
    assign o_e      = w_e[EW-1:0];
    assign o_ovf    = (w_e >= (EW+2)'(EXP_MAX));
    assign w_unused = i_m[CARRY];
endmodule

// File: rtl/fadd_norm_round.sv
// FP add/sub post-alignment: effective add/sub, one-bit-per-cycle normalize, RNE round, pack.
module fadd_norm_round
    import fpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          S_A,
    input  logic          S_B,
    input  logic [EW-1:0] E_O,
    input  logic [MW-1:0] M_A,
    input  logic [MW-1:0] M_B,
    input  logic          eq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   result,
    output logic          ovf,
    output logic          uf
);
    state_t        r_state, w_state_nxt;
    logic          r_sa, r_sb, r_eq;
    logic [EW-1:0] r_eo;
    logic [MW-1:0] r_ma, r_mb, r_m;
    logic [EW+1:0] r_e;
    logic [31:0]   r_result;
    logic          r_ovf, r_uf;

    logic          w_sub, w_zero, w_e_min;
    logic [MW-1:0] w_sum;
    logic [22:0]   w_rnd_frac;
    logic [EW-1:0] w_rnd_e;
    logic          w_rnd_ovf;

    assign w_sub   = (r_sa != r_sb);
    assign w_sum   = w_sub ? (r_ma - r_mb) : (r_ma + r_mb);
    assign w_zero  = (w_sub & r_eq) | (w_sum == '0);
    assign w_e_min = (r_e == (EW+2)'(1));

    fp_round_rne u_round (
        .i_m    (r_m),
        .i_e    (r_e),
        .o_frac (w_rnd_frac),
        .o_e    (w_rnd_e),
        .o_ovf  (w_rnd_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = ADD;
            ADD:     w_state_nxt = w_zero ? DONE : NORM;
            NORM:    if (r_m[HIDDEN]) w_state_nxt = ROUND;
                     else if (w_e_min) w_state_nxt = DONE;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_eq     <= 1'b0;
            r_eo     <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_uf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sa <= S_A;
                    r_sb <= S_B;
                    r_eq <= eq;
                    r_eo <= E_O;
                    r_ma <= M_A;
                    r_mb <= M_B;
                end
                ADD: begin
                    if (w_zero) begin
                        r_result <= '0;
                        r_ovf    <= 1'b0;
                        r_uf     <= 1'b0;
                    end else if (w_sum[CARRY]) begin
                        // Carry out: shift right once, keeping the dropped bit as sticky.
                        r_m <= {1'b0, w_sum[MW-1:2], w_sum[1] | w_sum[0]};
                        r_e <= {2'b00, r_eo} + (EW+2)'(1);
                    end else begin
                        r_m <= w_sum;
                        r_e <= {2'b00, r_eo};
                    end
                end
                NORM: if (!r_m[HIDDEN]) begin
                    if (w_e_min) begin
                        r_result <= {r_sa, 31'd0};
                        r_ovf    <= 1'b0;
                        r_uf     <= 1'b1;
                    end else begin
                        r_m <= {r_m[MW-2:0], 1'b0};
                        r_e <= r_e - (EW+2)'(1);
                    end
                end
                ROUND: begin
                    r_result <= w_rnd_ovf ? {r_sa, PINF[30:0]} : {r_sa, w_rnd_e, w_rnd_frac};
                    r_ovf    <= w_rnd_ovf;
                    r_uf     <= 1'b0;
                end
                DONE: if (out_ready) begin
                    r_ovf <= 1'b0;
                    r_uf  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign uf        = r_uf;
endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: directed vector table, control sequences, random ops vs value model.
module tb_fadd_norm_round;
    typedef struct {
        logic        sa;
        logic        sb;
        logic [7:0]  eo;
        logic [27:0] ma;
        logic [27:0] mb;
        logic        eq;
        logic [31:0] res;
        logic        ovf;
        logic        uf;
        int          lat;   // edges from accepting edge to out_valid
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        S_A, S_B, eq;
    logic [7:0]  E_O;
    logic [27:0] M_A, M_B;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        ovf, uf;

    int n_tests = 0;
    int n_fail  = 0;

    fadd_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S_A       (S_A),
        .S_B       (S_B),
        .E_O       (E_O),
        .M_A       (M_A),
        .M_B       (M_B),
        .eq        (eq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .uf        (uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-level reference: exact sum, leading-one normalize limited by the exponent floor,
    // nearest-even on the three bits below the 24-bit significand.
    function automatic vec_t model(input vec_t v);
        longint m, mant, rem;
        int     e, p, k;
        vec_t   r;
        r = v;
        r.ovf = 1'b0;
        r.uf  = 1'b0;
        m = (v.sa == v.sb) ? (longint'(v.ma) + longint'(v.mb)) : (longint'(v.ma) - longint'(v.mb));
        if (((v.sa != v.sb) && v.eq) || m == 0) begin
            r.res = 32'd0;
            r.lat = 1;
            return r;
        end
        e = int'(v.eo);
        if ((m >> 27) != 0) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end
        p = 26;
        while (((m >> p) & 1) == 0) p--;
        k = 26 - p;
        if (e - k < 1) begin
            r.res = {v.sa, 31'd0};
            r.uf  = 1'b1;
            r.lat = e + 1;
            return r;
        end
        m = m << k;
        e = e - k;
        r.lat = k + 3;
        mant = m >> 3;
        rem  = m & 7;
        if (rem > 4 || (rem == 4 && (mant & 1) == 1)) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            r.res = {v.sa, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else begin
            r.res = {v.sa, e[7:0], mant[22:0]};
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        S_A = v.sa;
        S_B = v.sb;
        E_O = v.eo;
        M_A = v.ma;
        M_B = v.mb;
        eq  = v.eq;
    endtask

    // Applies one op, keeps in_valid high with junk while busy, holds backpressure 'hold' cycles.
    task automatic run_op(input vec_t v, input int hold, input string tag);
        int lat;
        bit seen;
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        S_A = 1'($urandom); S_B = 1'($urandom); eq = 1'($urandom);
        E_O = 8'($urandom); M_A = 28'($urandom); M_B = 28'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            chk({tag, ".in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
            seen = out_valid;
        end
        in_valid = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: out_valid not seen within %0d edges, expected %0d", tag, lat, v.lat);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        chk({tag, ".latency"}, lat, v.lat);
        chk({tag, ".result"}, result, v.res);
        chk({tag, ".ovf"}, ovf, v.ovf);
        chk({tag, ".uf"}, uf, v.uf);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_result"}, result, v.res);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, out_valid, 0);
        chk({tag, ".drain_in_ready"}, in_ready, 1);
        chk({tag, ".drain_flags"}, {ovf, uf}, 0);
    endtask

    vec_t tbl[12];

    initial begin
        vec_t v;
        logic [27:0] raw, tmp;
        int d;

        // lat is counted from the accepting edge; the zero path is therefore 1 here (2 edges overall).
        tbl[0]  = '{1'b0, 1'b0, 8'd127, 28'h4000000, 28'h4000000, 1'b1, 32'h40000000, 1'b0, 1'b0, 3};
        tbl[1]  = '{1'b0, 1'b1, 8'd127, 28'h4000000, 28'h3000000, 1'b0, 32'h3E800000, 1'b0, 1'b0, 5};
        tbl[2]  = '{1'b0, 1'b1, 8'd127, 28'h6000000, 28'h6000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1};
        tbl[3]  = '{1'b0, 1'b0, 8'd127, 28'h4000000, 28'h0000004, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3};
        tbl[4]  = '{1'b0, 1'b0, 8'd127, 28'h4000000, 28'h000000C, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b0, 1'b0, 8'd254, 28'h7FFFFF8, 28'h7FFFFF8, 1'b1, 32'h7F800000, 1'b1, 1'b0, 3};
        tbl[6]  = '{1'b1, 1'b0, 8'd3,   28'h4000000, 28'h3F00000, 1'b0, 32'h80000000, 1'b0, 1'b1, 4};
        tbl[7]  = '{1'b0, 1'b0, 8'd127, 28'h7FFFFF8, 28'h0000004, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
        tbl[8]  = '{1'b1, 1'b1, 8'd130, 28'h4000000, 28'h2000000, 1'b0, 32'hC1400000, 1'b0, 1'b0, 3};
        tbl[9]  = '{1'b0, 1'b0, 8'd254, 28'h7FFFFF8, 28'h0000004, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3};
        tbl[10] = '{1'b0, 1'b1, 8'd1,   28'h4000000, 28'h1000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
        tbl[11] = '{1'b1, 1'b0, 8'd90,  28'h5000000, 28'h5000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        S_A = 1'b0; S_B = 1'b0; E_O = '0; M_A = '0; M_B = '0; eq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result", result, 0);
        chk("reset.flags", {ovf, uf}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_op(tbl[i], i % 3, $sformatf("vec%0d", i));

        // Long backpressure on a normal result.
        run_op(tbl[1], 10, "hold10");

        // Reset while normalizing: nothing may come out afterwards.
        drive(tbl[1]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_norm.in_ready", in_ready, 1);
        chk("rst_norm.out_valid", out_valid, 0);
        chk("rst_norm.result", result, 0);
        chk("rst_norm.flags", {ovf, uf}, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_norm.no_stale", out_valid, 0);
        end
        run_op(tbl[0], 0, "post_rst");

        for (int n = 0; n < 300; n++) begin
            v.sa = 1'($urandom);
            v.sb = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       v.eo = 8'($urandom_range(1, 8));
                1:       v.eo = 8'($urandom_range(240, 254));
                default: v.eo = 8'($urandom_range(1, 254));
            endcase
            v.ma = 28'h4000000 | {2'b00, 23'($urandom), 3'b000};
            raw  = 28'h4000000 | {2'b00, 23'($urandom), 3'b000};
            if ($urandom_range(0, 3) == 0) begin
                tmp = 28'd1 << $urandom_range(3, 7);
                raw = v.ma ^ tmp;
            end
            d = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 27);
            tmp  = (28'd1 << d) - 28'd1;
            v.mb = (raw >> d) | {27'd0, (raw & tmp) != 28'd0};
            if (v.mb > v.ma) begin
                tmp  = v.ma;
                v.ma = v.mb;
                v.mb = tmp;
            end
            v.eq = (v.ma == v.mb);
            v = model(v);
            run_op(v, $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
